// File: rtl/fft8_sample_loader_pkg.sv
// Shared constants and slot-placement helper for the 8-point real FFT front end.
// Sample k of a frame occupies the 32-bit field whose MSB is slotMsb(k).
package fft8_sample_loader_pkg;

  localparam int FFT_N  = 8;
  localparam int FLT_W  = 32;
  localparam int VEC_W  = FFT_N * FLT_W;
  localparam int SLOT_W = $clog2(FFT_N);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FFT_N - 1);

  // Sample 0 lands in the top field, sample 7 in the bottom one.
  function automatic int slotMsb(input int k);
    return VEC_W - 1 - FLT_W * k;
  endfunction

endpackage

// File: rtl/fft8_sample_loader_frame_bank.sv
// One 8x32 frame bank: single-slot write port, full 256-bit packed read.
// Register-based so the whole frame is visible to the combinational FFT at once.
module fft8_frame_bank
  import fft8_sample_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wrEn,
  input  logic [SLOT_W-1:0] wrSlot,
  input  logic [FLT_W-1:0]  wrData,
  output logic [VEC_W-1:0]  rdVector
);

  logic [FLT_W-1:0] mem [FFT_N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FFT_N; i++) begin
        mem[i] <= '0;
      end
    end else if (wrEn) begin
      mem[wrSlot] <= wrData;
    end
  end

  for (genvar gi = 0; gi < FFT_N; gi++) begin : gSlot
    assign rdVector[slotMsb(gi) -: FLT_W] = mem[gi];
  end

endmodule

// File: rtl/fft8_sample_loader.sv
// Ping-pong loader: packs a serial float32 stream into 8-sample frames for the FFT,
// flags framing errors (early or missing s_last) and counts them with saturation.
module fft8_sample_loader
  import fft8_sample_loader_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NPTS     = 8,
  parameter int ERRCNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [DATA_W-1:0]      s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [NPTS*DATA_W-1:0] frame_vector,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic                   frame_err,
  output logic [ERRCNT_W-1:0]    err_cnt
);

  logic              wrSelReg, wrSelNext;
  logic              rdSelReg, rdSelNext;
  logic [SLOT_W-1:0] idxReg, idxNext;
  logic [1:0]        fullReg, fullNext;
  logic              errPulseReg, errPulseNext;
  logic [ERRCNT_W-1:0] errCntReg, errCntNext;

  logic accept, handoff, lastSlot, earlyLast, missingLast, bankWrite;
  logic [1:0]            bankWe;
  logic [1:0][VEC_W-1:0] bankVec;

  assign s_ready      = !fullReg[wrSelReg];
  assign frame_valid  = fullReg[rdSelReg];
  assign frame_vector = bankVec[rdSelReg];
  assign frame_err    = errPulseReg;
  assign err_cnt      = errCntReg;

  assign accept      = s_valid && s_ready;
  assign handoff     = frame_valid && frame_ready;
  assign lastSlot    = (idxReg == LAST_SLOT);
  assign earlyLast   = accept && s_last && !lastSlot;
  assign missingLast = accept && !s_last && lastSlot;
  // The sample carrying an early s_last is dropped along with its partial frame.
  assign bankWrite   = accept && !earlyLast && !flush;

  for (genvar gi = 0; gi < 2; gi++) begin : gBank
    assign bankWe[gi] = bankWrite && (wrSelReg == 1'(gi));

    fft8_frame_bank uBank (
      .clk      (clk),
      .rst_n    (rst_n),
      .wrEn     (bankWe[gi]),
      .wrSlot   (idxReg),
      .wrData   (s_data),
      .rdVector (bankVec[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrSelReg    <= 1'b0;
      rdSelReg    <= 1'b0;
      idxReg      <= '0;
      fullReg     <= '0;
      errPulseReg <= 1'b0;
      errCntReg   <= '0;
    end else begin
      wrSelReg    <= wrSelNext;
      rdSelReg    <= rdSelNext;
      idxReg      <= idxNext;
      fullReg     <= fullNext;
      errPulseReg <= errPulseNext;
      errCntReg   <= errCntNext;
    end
  end

  always_comb begin
    wrSelNext    = wrSelReg;
    rdSelNext    = rdSelReg;
    idxNext      = idxReg;
    fullNext     = fullReg;
    errPulseNext = 1'b0;
    errCntNext   = errCntReg;
    if (flush) begin
      wrSelNext = 1'b0;
      rdSelNext = 1'b0;
      idxNext   = '0;
      fullNext  = '0;
    end else begin
      // Handoff and completion can coincide; they always hit different banks.
      if (handoff) begin
        fullNext[rdSelReg] = 1'b0;
        rdSelNext          = !rdSelReg;
      end
      if (earlyLast) begin
        idxNext = '0;
      end else if (accept) begin
        if (lastSlot) begin
          fullNext[wrSelReg] = 1'b1;
          wrSelNext          = !wrSelReg;
          idxNext            = '0;
        end else begin
          idxNext = idxReg + SLOT_W'(1);
        end
      end
      if (earlyLast || missingLast) begin
        errPulseNext = 1'b1;
        if (errCntReg != '1) begin
          errCntNext = errCntReg + ERRCNT_W'(1);
        end
      end
    end
  end

endmodule
